// File: rtl/prvp_spi_master_tx.sv
// Transmit shifter of the SPI/C2C master: shifts FIFO words onto SDO lines on clkgen falling-edge
// strobes, and gates the SPI clock so it only runs while transmit data is available.
module prvp_spi_master_tx (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        tx_edge,
    input  logic        en_quad_in,
    input  logic [15:0] counter_in,
    input  logic        counter_in_upd,
    input  logic [31:0] data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        tx_done,
    output logic        clk_en_o,
    output logic        sdo0,
    output logic        sdo1,
    output logic        sdo2,
    output logic        sdo3
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRANSMIT  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] target_q, target_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        quad_q, quad_d;
    logic        clk_en_q, clk_en_d;

    logic [15:0] quad_target;
    logic        word_boundary;

    // Quad mode moves four bits per edge, so a partial final nibble still costs one edge.
    assign quad_target   = (len_q >> 2) + {15'd0, |len_q[1:0]};
    assign word_boundary = quad_q ? (cnt_q[2:0] == 3'd7) : (cnt_q[4:0] == 5'd31);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            len_q    <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            quad_q   <= 1'b0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            quad_q   <= quad_d;
            clk_en_q <= clk_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        quad_d     = quad_q;
        clk_en_d   = clk_en_q;
        data_ready = 1'b0;
        tx_done    = 1'b0;

        if (counter_in_upd) begin
            len_d = counter_in;
        end

        case (state_q)
            IDLE: begin
                if (en && data_valid && (len_q != 16'd0)) begin
                    data_ready = 1'b1;
                    shift_d    = data;
                    cnt_d      = '0;
                    quad_d     = en_quad_in;
                    target_d   = en_quad_in ? quad_target : len_q;
                    clk_en_d   = 1'b1;
                    state_d    = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (tx_edge) begin
                    cnt_d   = cnt_q + 16'd1;
                    shift_d = quad_q ? (shift_q << 4) : (shift_q << 1);
                    if (cnt_q == target_q - 16'd1) begin
                        tx_done  = 1'b1;
                        clk_en_d = 1'b0;
                        state_d  = IDLE;
                    end else if (word_boundary) begin
                        if (data_valid) begin
                            data_ready = 1'b1;
                            shift_d    = data;
                        end else begin
                            // Starved: stop the SPI clock until the FIFO catches up.
                            clk_en_d = 1'b0;
                            state_d  = WAIT_DATA;
                        end
                    end
                end
            end
            WAIT_DATA: begin
                if (data_valid) begin
                    data_ready = 1'b1;
                    shift_d    = data;
                    clk_en_d   = 1'b1;
                    state_d    = TRANSMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clk_en_o = clk_en_q;
    assign sdo0     = quad_q ? shift_q[28] : shift_q[31];
    assign sdo1     = quad_q & shift_q[29];
    assign sdo2     = quad_q & shift_q[30];
    assign sdo3     = quad_q & shift_q[31];

endmodule
